// File: rtl/ws2812_pixel_tx.sv
// WS2812 pixel serialiser: valid/ready pixel stream in, NZR bitcodes plus latch period out.
// Optional WS2812_BRIGHTNESS_EN scales each byte by (brightness+1)/256 at shift-register load.
`timescale 1ns/1ps
module ws2812_pixel_tx #(
  parameter int BITS_PER_PIX = 24,
  parameter int T_BIT        = 125,
  parameter int T0H          = 40,
  parameter int T1H          = 80,
  parameter int T_RESET      = 8000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BITS_PER_PIX-1:0] pix_data,
  input  logic                    pix_last,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic [7:0]              brightness,
  output logic                    dout,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    underrun
);

  localparam int CW = (T_BIT > 1) ? $clog2(T_BIT) : 1;
  localparam int IW = (BITS_PER_PIX > 1) ? $clog2(BITS_PER_PIX) : 1;
  localparam int LW = (T_RESET > 1) ? $clog2(T_RESET) : 1;

  localparam logic [CW-1:0] BIT_END = CW'(T_BIT - 1);
  localparam logic [CW-1:0] HI0     = CW'(T0H);
  localparam logic [CW-1:0] HI1     = CW'(T1H);
  localparam logic [IW-1:0] IDX_END = IW'(BITS_PER_PIX - 1);
  localparam logic [LW-1:0] LAT_END = LW'(T_RESET - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BIT,
    S_LATCH
  } state_t;

  state_t state;
  state_t state_n;

  logic [BITS_PER_PIX-1:0] buf_data;
  logic                    buf_last;
  logic                    full;
  logic [BITS_PER_PIX-1:0] shreg;
  logic                    cur_last;
  logic [CW-1:0]           bit_cnt;
  logic [IW-1:0]           bit_idx;
  logic [LW-1:0]           lat_cnt;

  logic                    accept;
  logic                    load;
  logic                    bit_end;
  logic                    pix_end;
  logic [BITS_PER_PIX-1:0] load_word;

  assign pix_ready = !full && !reset;
  assign accept    = pix_valid && pix_ready;
  assign bit_end   = (bit_cnt == BIT_END);
  assign pix_end   = bit_end && (bit_idx == IDX_END);
  assign busy      = (state != S_IDLE);

`ifdef WS2812_BRIGHTNESS_EN
  always_comb begin
    load_word = buf_data;
    for (int i = 0; i < BITS_PER_PIX / 8; i++) begin
      load_word[8*i +: 8] = 8'((17'(buf_data[8*i +: 8]) *
                               (17'(brightness) + 17'd1)) >> 8);
    end
  end
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign load_word = buf_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    load       = 1'b0;
    dout       = 1'b0;
    frame_done = 1'b0;
    underrun   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (full) begin
          load    = 1'b1;
          state_n = S_BIT;
        end
      end
      S_BIT: begin
        dout = (bit_cnt < (shreg[BITS_PER_PIX-1] ? HI1 : HI0));
        if (pix_end) begin
          // last pixel wins over a buffered one: that one opens the next frame
          if (cur_last) begin
            state_n = S_LATCH;
          end else if (full) begin
            load = 1'b1;
          end else begin
            state_n  = S_LATCH;
            underrun = 1'b1;
          end
        end
      end
      S_LATCH: begin
        if (lat_cnt == LAT_END) begin
          frame_done = 1'b1;
          state_n    = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_data <= '0;
      buf_last <= 1'b0;
      full     <= 1'b0;
      shreg    <= '0;
      cur_last <= 1'b0;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      lat_cnt  <= '0;
    end else begin
      if (load) begin
        shreg    <= load_word;
        cur_last <= buf_last;
        full     <= 1'b0;
        bit_cnt  <= '0;
        bit_idx  <= '0;
      end else if (state == S_BIT) begin
        if (bit_end) begin
          bit_cnt <= '0;
          bit_idx <= bit_idx + 1'b1;
          shreg   <= {shreg[BITS_PER_PIX-2:0], 1'b0};
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      if (accept) begin
        buf_data <= pix_data;
        buf_last <= pix_last;
        full     <= 1'b1;
      end
      if (state == S_LATCH) lat_cnt <= lat_cnt + 1'b1;
      else                  lat_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_ws2812_pixel_tx.sv
// Bench for ws2812_pixel_tx: decodes dout back into pixel words and
// scoreboards them against the words offered on the pixel stream.
`timescale 1ns/1ps
module tb_ws2812_pixel_tx;

  localparam int BPP = 24;
  localparam int TB  = 125;
  localparam int T0  = 40;
  localparam int T1  = 80;
  localparam int TR  = 8000;
  localparam int FRM = BPP * TB;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [BPP-1:0] pix_data = '0;
  logic           pix_last = 1'b0;
  logic           pix_valid = 1'b0;
  logic           pix_ready;
  logic [7:0]     brightness = 8'hFF;
  logic           dout;
  logic           busy;
  logic           frame_done;
  logic           underrun;

  int errors = 0;
  int checks = 0;

  logic [BPP-1:0] exp_q[$];
  logic [BPP-1:0] obs_q[$];
  int             start_q[$];
  int             shape_err = 0;
  int             tick = 0;

  ws2812_pixel_tx #(
    .BITS_PER_PIX(BPP), .T_BIT(TB), .T0H(T0), .T1H(T1), .T_RESET(TR)
  ) dut (
    .clk(clk), .reset(reset),
    .pix_data(pix_data), .pix_last(pix_last),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .brightness(brightness), .dout(dout), .busy(busy),
    .frame_done(frame_done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // line decoder: bits are fixed T_BIT windows starting at a rising dout
  initial begin
    bit             m_in = 0;
    int             m_cyc = 0, m_hi = 0, m_nb = 0, m_end = 0, m_start = 0;
    logic [BPP-1:0] m_word = '0;
    forever begin
      @(negedge clk);
      tick++;
      if (reset) begin
        m_in = 0;
        m_nb = 0;
      end else if (!m_in) begin
        if (dout) begin
          if (m_nb != 0 && tick != m_end + 1) shape_err++;
          if (m_nb == 0) m_start = tick;
          m_in = 1; m_cyc = 1; m_hi = 1;
        end
      end else begin
        m_cyc++;
        if (dout) begin
          if (m_hi == m_cyc - 1) m_hi++;
          else shape_err++;
        end
        if (m_cyc == TB) begin
          if (m_hi != T0 && m_hi != T1) shape_err++;
          m_word = {m_word[BPP-2:0], m_hi == T1};
          m_nb++; m_in = 0; m_end = tick;
          if (m_nb == BPP) begin
            obs_q.push_back(m_word);
            start_q.push_back(m_start);
            m_nb = 0;
          end
        end
      end
    end
  end

  function automatic logic [BPP-1:0] model(input logic [BPP-1:0] d,
                                          input logic [7:0] br);
    logic [BPP-1:0] r;
    r = d;
`ifdef WS2812_BRIGHTNESS_EN
    for (int i = 0; i < BPP / 8; i++)
      r[8*i +: 8] = 8'((int'(d[8*i +: 8]) * (int'(br) + 1)) >> 8);
`else
    r = d ^ {BPP{br[0] & 1'b0}};
`endif
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [BPP-1:0] d, input logic l);
    int n = 0;
    pix_data = d; pix_last = l; pix_valid = 1'b1;
    while (pix_ready !== 1'b1 && n < 20000) begin step(); n++; end
    checks++;
    if (n >= 20000) begin
      errors++;
      $display("FAIL send_timeout: pix_ready=%b required 1", pix_ready);
    end
    @(posedge clk);
    exp_q.push_back(model(d, brightness));
    #1;
    pix_valid = 1'b0;
  endtask

  task automatic wait_idle(output int fd, output int un);
    int n = 0;
    fd = 0; un = 0;
    while (busy === 1'b1 && n < 30000) begin
      step(); n++;
      if (frame_done === 1'b1) fd++;
      if (underrun === 1'b1) un++;
    end
    checks++;
    if (n >= 30000) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b required 0", busy);
    end
  endtask

  task automatic get_word(output logic [BPP-1:0] o, output logic [BPP-1:0] e,
                          output int st, output bit ok);
    int n = 0;
    while (obs_q.size() == 0 && n < 4000) begin step(); n++; end
    ok = (obs_q.size() != 0) && (exp_q.size() != 0);
    o = '0; e = '1; st = 0;
    if (obs_q.size() != 0) begin o = obs_q.pop_front(); st = start_q.pop_front(); end
    if (exp_q.size() != 0) e = exp_q.pop_front();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks += 5;
    if (dout !== 1'b0)       begin errors++; $display("FAIL rst_dout: got %b want 0", dout); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_fd: got %b want 0", frame_done); end
    if (underrun !== 1'b0)   begin errors++; $display("FAIL rst_un: got %b want 0", underrun); end
    if (pix_ready !== 1'b0)  begin errors++; $display("FAIL rst_ready: got %b want 0", pix_ready); end
    reset = 1'b0;
    step();
    checks++;
    if (pix_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b want 1", pix_ready); end
  endtask

  task automatic test_single_pixel();
    int se = shape_err, lat_bad = 0, fd_cnt = 0, fd_at = -1, st;
    logic first_hi, busy_10999, busy_11001;
    logic [BPP-1:0] o, e;
    bit ok;
    send(24'hFF0000, 1'b1);
    for (int k = 1; k <= 11001; k++) begin
      step();
      if (k == 1) first_hi = dout;
      if (k >= FRM + 1 && k <= FRM + TR && dout !== 1'b0) lat_bad++;
      if (frame_done === 1'b1) begin fd_cnt++; fd_at = k; end
      if (k == 10999) busy_10999 = busy;
      if (k == 11001) busy_11001 = busy;
    end
    checks += 7;
    if (first_hi !== 1'b1)  begin errors++; $display("FAIL single_first_hi: got %b want 1", first_hi); end
    if (lat_bad != 0)       begin errors++; $display("FAIL single_latch_low: got %0d high cycles want 0", lat_bad); end
    if (fd_cnt != 1 || fd_at != FRM + TR)
      begin errors++; $display("FAIL single_frame_done: got %0d pulses at %0d want 1 at %0d", fd_cnt, fd_at, FRM + TR); end
    if (busy_10999 !== 1'b1) begin errors++; $display("FAIL single_busy_latch: got %b want 1", busy_10999); end
    if (busy_11001 !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", busy_11001); end
    get_word(o, e, st, ok);
    if (!ok || o !== 24'hFF0000) begin errors++; $display("FAIL single_word: got %h want %h", o, 24'hFF0000); end
    if (shape_err != se) begin errors++; $display("FAIL single_shape: got %0d bad bits want 0", shape_err - se); end
  endtask

  task automatic test_back_to_back();
    int se = shape_err, fd, un, st1, st2;
    logic r0, r1;
    logic [BPP-1:0] o1, e1, o2, e2;
    bit ok1, ok2;
    send(24'h000001, 1'b0);
    r0 = pix_ready;
    step();
    r1 = pix_ready;
    send(24'h800000, 1'b1);
    wait_idle(fd, un);
    get_word(o1, e1, st1, ok1);
    get_word(o2, e2, st2, ok2);
    checks += 7;
    if (r0 !== 1'b0) begin errors++; $display("FAIL b2b_ready_drop: got %b want 0", r0); end
    if (r1 !== 1'b1) begin errors++; $display("FAIL b2b_ready_rise: got %b want 1", r1); end
    if (!ok1 || o1 !== e1) begin errors++; $display("FAIL b2b_word1: got %h want %h", o1, e1); end
    if (!ok2 || o2 !== e2) begin errors++; $display("FAIL b2b_word2: got %h want %h", o2, e2); end
    if (st2 - st1 != FRM) begin errors++; $display("FAIL b2b_gap: got %0d want %0d", st2 - st1, FRM); end
    if (fd != 1 || un != 0) begin errors++; $display("FAIL b2b_pulses: got fd=%0d un=%0d want 1 0", fd, un); end
    if (shape_err != se) begin errors++; $display("FAIL b2b_shape: got %0d bad bits want 0", shape_err - se); end
  endtask

  task automatic test_underrun();
    int un_cnt = 0, un_at = -1, fd_cnt = 0, fd_at = -1, st;
    logic [BPP-1:0] o, e;
    bit ok;
    send(24'h123456, 1'b0);
    for (int k = 1; k <= 11001; k++) begin
      step();
      if (underrun === 1'b1) begin un_cnt++; un_at = k; end
      if (frame_done === 1'b1) begin fd_cnt++; fd_at = k; end
    end
    get_word(o, e, st, ok);
    checks += 3;
    if (un_cnt != 1 || un_at != FRM)
      begin errors++; $display("FAIL underrun_pulse: got %0d at %0d want 1 at %0d", un_cnt, un_at, FRM); end
    if (fd_cnt != 1 || fd_at != FRM + TR)
      begin errors++; $display("FAIL underrun_fd: got %0d at %0d want 1 at %0d", fd_cnt, fd_at, FRM + TR); end
    if (!ok || o !== e) begin errors++; $display("FAIL underrun_word: got %h want %h", o, e); end
  endtask

  task automatic test_reset_mid();
    int fd = 0, bz = 0;
    logic d0;
    send(24'hFFFFFF, 1'b1);
    send(24'hABCDEF, 1'b1);
    repeat (1 + 5 * TB + 20 - 2) step();
    d0 = dout;
    reset = 1'b1;
    step();
    checks += 4;
    if (d0 !== 1'b1)       begin errors++; $display("FAIL mid_pre_dout: got %b want 1", d0); end
    if (dout !== 1'b0)     begin errors++; $display("FAIL mid_dout: got %b want 0", dout); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
    if (pix_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_rst: got %b want 0", pix_ready); end
    reset = 1'b0;
    step();
    checks++;
    if (pix_ready !== 1'b1) begin errors++; $display("FAIL mid_buffer_empty: got %b want 1", pix_ready); end
    for (int k = 0; k < 9000; k++) begin
      step();
      if (frame_done === 1'b1) fd++;
      if (busy === 1'b1) bz++;
    end
    checks += 2;
    if (fd != 0 || bz != 0) begin errors++; $display("FAIL mid_quiet: got fd=%0d busy=%0d want 0 0", fd, bz); end
    if (obs_q.size() != 0) begin errors++; $display("FAIL mid_no_word: got %0d words want 0", obs_q.size()); end
    exp_q.delete();
    obs_q.delete();
    start_q.delete();
  endtask

  task automatic test_brightness();
    int fd, un, st;
    logic [BPP-1:0] o, e, want;
    bit ok;
`ifdef WS2812_BRIGHTNESS_EN
    want = 24'h7F407F;
`else
    want = 24'hFF80FF;
`endif
    brightness = 8'h7F;
    send(24'hFF80FF, 1'b1);
    wait_idle(fd, un);
    get_word(o, e, st, ok);
    checks += 2;
    if (!ok || o !== e) begin errors++; $display("FAIL bright_model: got %h want %h", o, e); end
    if (o !== want)     begin errors++; $display("FAIL bright_word: got %h want %h", o, want); end
    brightness = 8'hFF;
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_back_to_back();
    test_underrun();
    test_reset_mid();
    test_brightness();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
